// File: rtl/hilo_ctrl_if.sv
// Bus between hilo_ctrl, the datapath (mthi/mtlo/mfhi/mflo) and the iterative divider.
// slave is the controller's view; master is the view of whatever surrounds it.
interface hilo_ctrl_if;
    // datapath requests
    logic        div_start;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        rd_req;
    // divider results
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        div_err;
    // controller outputs
    logic        div_control;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        stall;
    logic        wr_conflict;

    modport slave (
        input  div_start, hi_we, lo_we, wdata, rd_req, div_hi, div_lo, div_err,
        output div_control, hi_q, lo_q, busy, done, div_zero, stall, wr_conflict
    );

    modport master (
        output div_start, hi_we, lo_we, wdata, rd_req, div_hi, div_lo, div_err,
        input  div_control, hi_q, lo_q, busy, done, div_zero, stall, wr_conflict
    );
endinterface

// File: rtl/hilo_ctrl.sv
// Divide sequencer and HI/LO register file. Drives the divider enable, counts its
// fixed latency, captures remainder/quotient into HI/LO and serves mthi/mtlo.
// DIV_LAT must stay within 2..63 so that DIV_LAT-1 fits the 6-bit counter.
module hilo_ctrl #(
    parameter int DIV_LAT = 34
) (
    input  logic      clk,
    input  logic      reset,
    hilo_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] COOL = 2'd2;

    localparam logic [5:0] LAST = 6'(DIV_LAT - 1);

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [31:0] hi_r, lo_r;
    logic        done_r, dz_r, wc_r;

    logic in_idle, in_run, in_cool;
    logic start_ok, abort, capture, wr_any;

    assign in_idle  = (state == IDLE);
    assign in_run   = (state == RUN);
    assign in_cool  = (state == COOL);
    assign wr_any   = bus.hi_we | bus.lo_we;
    // COOL already gave the divider its low-enable cycle, so a start seen on the
    // COOL->IDLE edge is taken straight away; this is what makes back-to-back
    // divides start exactly DIV_LAT+1 edges apart.
    assign start_ok = bus.div_start & (in_idle | in_cool);
    // divide-by-zero wins over the final count on the same edge
    assign abort    = in_run & bus.div_err;
    assign capture  = in_run & ~bus.div_err & (cnt == LAST);

    // sequencer state and latency counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state <= RUN;
                        cnt   <= 6'd0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 6'd1;
                    if (abort || capture) state <= COOL;
                end
                COOL: begin
                    if (start_ok) begin
                        state <= RUN;
                        cnt   <= 6'd0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // architectural HI/LO: datapath writes only when idle, divider capture otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (capture) begin
            hi_r <= bus.div_hi;
            lo_r <= bus.div_lo;
        end else if (in_idle) begin
            if (bus.hi_we) hi_r <= bus.wdata;
            if (bus.lo_we) lo_r <= bus.wdata;
        end
    end

    // one-cycle status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r <= 1'b0;
            dz_r   <= 1'b0;
            wc_r   <= 1'b0;
        end else begin
            done_r <= capture;
            dz_r   <= abort;
            wc_r   <= wr_any & ~in_idle;
        end
    end

    // enable is decoded from state so reset drops it without waiting for an edge
    assign bus.div_control = in_run;
    assign bus.busy        = ~in_idle;
    assign bus.stall       = bus.rd_req & ~in_idle;
    assign bus.hi_q        = hi_r;
    assign bus.lo_q        = lo_r;
    assign bus.done        = done_r;
    assign bus.div_zero    = dz_r;
    assign bus.wr_conflict = wc_r;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: behavioural divider, age-based reference model checked
// every cycle, a table of divides, hand sequences for corner cases, random traffic.
module tb_hilo_ctrl;
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_ctrl_if bus ();
    hilo_ctrl #(.DIV_LAT(DIV_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural divider ----------------
    logic [31:0] opa, opb, la, lb;
    int dcnt;
    always @(posedge clk) begin
        if (!bus.div_control) begin
            dcnt <= 0;
            la   <= opa;
            lb   <= opb;
        end else begin
            dcnt <= dcnt + 1;
        end
    end
    // results only valid on the cycle before the capture edge; junk otherwise
    assign bus.div_lo  = (dcnt == DIV_LAT-1 && lb != 0) ? la / lb : (32'hDEAD_0000 | 32'(dcnt));
    assign bus.div_hi  = (dcnt == DIV_LAT-1 && lb != 0) ? la % lb : (32'hBEEF_0000 | 32'(dcnt));
    assign bus.div_err = bus.div_control && (lb == 0) && (dcnt >= 2);

    // ---------------- reference model ----------------
    // m_age: -1 idle, 0..DIV_LAT-1 cycles since the accepted start, DIV_LAT = cool-down
    int          m_age;
    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic        m_done, m_dz, m_wc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_age <= -1; m_hi <= 0; m_lo <= 0; m_a <= 0; m_b <= 0;
            m_done <= 0; m_dz <= 0; m_wc <= 0;
        end else begin
            m_done <= 0; m_dz <= 0; m_wc <= 0;
            if (m_age < 0) begin
                if (bus.hi_we) m_hi <= bus.wdata;
                if (bus.lo_we) m_lo <= bus.wdata;
                if (bus.div_start) begin m_age <= 0; m_a <= opa; m_b <= opb; end
            end else begin
                m_wc <= bus.hi_we | bus.lo_we;
                if (m_age >= DIV_LAT) begin
                    if (bus.div_start) begin m_age <= 0; m_a <= opa; m_b <= opb; end
                    else m_age <= -1;
                end else if (m_b == 0 && m_age >= 2) begin
                    m_dz <= 1; m_age <= DIV_LAT;
                end else if (m_age == DIV_LAT-1) begin
                    m_hi <= m_a % m_b; m_lo <= m_a / m_b; m_done <= 1; m_age <= DIV_LAT;
                end else begin
                    m_age <= m_age + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("m_hi_q",   bus.hi_q, m_hi);
        check("m_lo_q",   bus.lo_q, m_lo);
        check("m_busy",   32'(bus.busy), 32'(m_age >= 0));
        check("m_divctl", 32'(bus.div_control), 32'(m_age >= 0 && m_age < DIV_LAT));
        check("m_done",   32'(bus.done), 32'(m_done));
        check("m_dz",     32'(bus.div_zero), 32'(m_dz));
        check("m_wc",     32'(bus.wr_conflict), 32'(m_wc));
        check("m_stall",  32'(bus.stall), 32'(bus.rd_req && m_age >= 0));
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy && n < 200) begin cyc(); n++; end
        check(nm, 32'(n < 200), 32'd1);
    endtask

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int exp_busy,
                           input bit exp_dz, input logic [31:0] ehi, input logic [31:0] elo);
        int bc = 0, nd = 0, nz = 0;
        opa = a; opb = b; bus.div_start = 1'b1;
        cyc();
        bus.div_start = 1'b0;
        while (bus.busy && bc < 200) begin
            if (bus.done) begin nd++; check("done_pos", 32'(bc), 32'(DIV_LAT)); end
            if (bus.div_zero) nz++;
            if (bus.done || bus.div_zero) check("cool_ctl_low", 32'(bus.div_control), 32'd0);
            bc++;
            cyc();
        end
        check("busy_len", 32'(bc), 32'(exp_busy));
        check("done_cnt", 32'(nd), exp_dz ? 32'd0 : 32'd1);
        check("dz_cnt",   32'(nz), 32'(exp_dz));
        check("res_hi",   bus.hi_q, ehi);
        check("res_lo",   bus.lo_q, elo);
    endtask

    typedef struct {
        logic [31:0] a, b;
        bit          pre;
        logic [31:0] pre_hi;
        int          exp_busy;
        bit          exp_dz;
        logic [31:0] ehi, elo;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{32'd100,        32'd7,    1'b0, 32'h0,         DIV_LAT+1, 1'b0, 32'd2,         32'd14};
        tbl[1] = '{32'd5,          32'd0,    1'b1, 32'hAAAA_AAAA, 4,         1'b1, 32'hAAAA_AAAA, 32'd14};
        tbl[2] = '{32'hFFFF_FFFF,  32'h10,   1'b0, 32'h0,         DIV_LAT+1, 1'b0, 32'hF,         32'h0FFF_FFFF};
        tbl[3] = '{32'd1000,       32'd33,   1'b0, 32'h0,         DIV_LAT+1, 1'b0, 32'd10,        32'd30};
        tbl[4] = '{32'd7,          32'd9,    1'b0, 32'h0,         DIV_LAT+1, 1'b0, 32'd7,         32'd0};

        reset = 1'b1;
        bus.div_start = 0; bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0; bus.rd_req = 0;
        opa = 0; opb = 1;
        cyc(); cyc();
        bus.rd_req = 1'b1; #1;
        check("rst_hi",   bus.hi_q, 32'd0);
        check("rst_lo",   bus.lo_q, 32'd0);
        check("rst_ctl",  32'(bus.div_control), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_dz",   32'(bus.div_zero), 32'd0);
        check("rst_wc",   32'(bus.wr_conflict), 32'd0);
        check("rst_stall",32'(bus.stall), 32'd0);
        bus.rd_req = 1'b0;
        reset = 1'b0;
        cyc();

        // table of divides
        for (int i = 0; i < 5; i++) begin
            if (tbl[i].pre) begin
                bus.hi_we = 1'b1; bus.wdata = tbl[i].pre_hi;
                cyc();
                bus.hi_we = 1'b0;
                check("mthi", bus.hi_q, tbl[i].pre_hi);
            end
            run_div(tbl[i].a, tbl[i].b, tbl[i].exp_busy, tbl[i].exp_dz, tbl[i].ehi, tbl[i].elo);
        end

        // write and read while busy
        opa = 100; opb = 7; bus.div_start = 1'b1;
        cyc();
        bus.div_start = 1'b0;
        bus.lo_we = 1'b1; bus.wdata = 32'h1234; bus.rd_req = 1'b1; #1;
        check("cf_stall0", 32'(bus.stall), 32'd1);
        cyc();
        bus.lo_we = 1'b0;
        check("cf_wc",   32'(bus.wr_conflict), 32'd1);
        check("cf_lo_kept", bus.lo_q, 32'd0);
        for (int n = 0; n < 200 && bus.busy; n++) begin
            check("cf_stall", 32'(bus.stall), 32'd1);
            cyc();
        end
        check("cf_lo", bus.lo_q, 32'd14);
        check("cf_hi", bus.hi_q, 32'd2);
        check("cf_stall_idle", 32'(bus.stall), 32'd0);
        bus.rd_req = 1'b0;

        // back-to-back with div_start held high
        opa = 32'hFFFF_FFFF; opb = 32'h10; bus.div_start = 1'b1;
        cyc();
        for (int i = 1; i <= DIV_LAT; i++) cyc();
        check("b2b_done1", 32'(bus.done), 32'd1);
        check("b2b_cool",  32'(bus.div_control), 32'd0);
        check("b2b_lo1",   bus.lo_q, 32'h0FFF_FFFF);
        check("b2b_hi1",   bus.hi_q, 32'hF);
        opa = 9; opb = 3;
        cyc();
        check("b2b_accept", 32'(bus.div_control), 32'd1);
        check("b2b_busy",   32'(bus.busy), 32'd1);
        bus.div_start = 1'b0;
        for (int i = 1; i <= DIV_LAT; i++) cyc();
        check("b2b_done2", 32'(bus.done), 32'd1);
        check("b2b_lo2",   bus.lo_q, 32'd3);
        check("b2b_hi2",   bus.hi_q, 32'd0);
        wait_idle("b2b_idle");

        // writes and start together in IDLE
        opa = 1000; opb = 33;
        bus.wdata = 32'd7; bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.div_start = 1'b1;
        cyc();
        bus.hi_we = 0; bus.lo_we = 0; bus.div_start = 0;
        check("sim_hi", bus.hi_q, 32'd7);
        check("sim_lo", bus.lo_q, 32'd7);
        check("sim_wc", 32'(bus.wr_conflict), 32'd0);
        wait_idle("sim_idle");
        check("sim_hi_cap", bus.hi_q, 32'd10);
        check("sim_lo_cap", bus.lo_q, 32'd30);

        // asynchronous reset mid-divide
        opa = 100; opb = 7; bus.div_start = 1'b1;
        cyc();
        bus.div_start = 1'b0;
        repeat (10) cyc();
        #1 reset = 1'b1;
        #1;
        check("ar_ctl",  32'(bus.div_control), 32'd0);
        check("ar_busy", 32'(bus.busy), 32'd0);
        check("ar_hi",   bus.hi_q, 32'd0);
        check("ar_lo",   bus.lo_q, 32'd0);
        cyc();
        reset = 1'b0;
        cyc();
        run_div(32'd9, 32'd3, DIV_LAT+1, 1'b0, 32'd0, 32'd3);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.div_start = ($urandom_range(0, 7) == 0);
            bus.hi_we     = ($urandom_range(0, 3) == 0);
            bus.lo_we     = ($urandom_range(0, 3) == 0);
            bus.wdata     = $urandom;
            bus.rd_req    = $urandom_range(0, 1) == 1;
            opa = $urandom;
            case ($urandom_range(0, 5))
                0:       opb = 32'd0;
                1, 2:    opb = 32'($urandom_range(1, 16));
                default: opb = $urandom | 32'd1;
            endcase
            cyc();
        end
        bus.div_start = 0; bus.hi_we = 0; bus.lo_we = 0; bus.rd_req = 0;
        wait_idle("rand_idle");
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
